exec_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit for the execute stage; parametrised in XLEN.

---
 rtl/exec_muldiv_pkg.sv | 24 ++
 rtl/exec_muldiv_div_step.sv | 22 ++
 rtl/exec_muldiv.sv | 152 +++++++++++++++
 tb/tb_exec_muldiv.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_muldiv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit:
// opcode fields, funct3 operation codes and FSM state encodings.
package exec_muldiv_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/exec_muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module exec_muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic          fits;

    assign shifted  = {rem, quo[XLEN-1]};
    assign fits     = (shifted >= {1'b0, divisor});
    // When the divisor fits the difference is below the divisor, so XLEN bits suffice.
    assign rem_next = fits ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/exec_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with a sign fix-up cycle at the end.
module exec_muldiv
    import exec_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op;
    logic                neg_a;
    logic                neg_b;
    logic [XLEN-1:0]     mcand;
    logic [2*XLEN-1:0]   acc;

    logic                accept;
    logic                a_sgn, b_sgn, in_neg_a, in_neg_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        if (funct3[2]) begin
            a_sgn = !funct3[0];
            b_sgn = !funct3[0];
        end else begin
            a_sgn = (funct3 == MULH) || (funct3 == MULHSU);
            b_sgn = (funct3 == MULH);
        end
        in_neg_a = a_sgn && opr1[XLEN-1];
        in_neg_b = b_sgn && opr2[XLEN-1];
        mag_a    = in_neg_a ? -opr1 : opr1;
        mag_b    = in_neg_b ? -opr2 : opr2;
        div_zero = (opr2 == '0);
        div_ovf  = !funct3[0] && (opr1 == MIN_VAL) && (opr2 == '1);
        special  = funct3[2] && (div_zero || div_ovf);
        if (div_zero) special_res = funct3[1] ? opr1 : '1;
        else          special_res = funct3[1] ? '0 : MIN_VAL;
    end

    // Multiply: accumulate into the high half, shift the multiplier out of the low half.
    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_addend = acc[0] ? mcand : '0;
    assign mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc[XLEN-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    logic [XLEN-1:0] div_rem_next, div_quo_next;

    exec_muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem      (acc[2*XLEN-1:XLEN]),
        .quo      (acc[XLEN-1:0]),
        .divisor  (mcand),
        .rem_next (div_rem_next),
        .quo_next (div_quo_next)
    );

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op[2])           fix_res = op[1] ? rem_fix : quo_fix;
        else if (op == MUL)  fix_res = prod_fix[XLEN-1:0];
        else                 fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op        <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            op    <= funct3;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            cnt   <= '0;
            if (funct3[2]) begin
                mcand <= mag_b;
                acc   <= {{XLEN{1'b0}}, mag_a};
            end else begin
                mcand <= mag_a;
                acc   <= {{XLEN{1'b0}}, mag_b};
            end
            if (special) begin
                result    <= special_res;
                out_valid <= 1'b1;
                state     <= ST_DONE;
            end else begin
                out_valid <= 1'b0;
                state     <= funct3[2] ? ST_DIV : ST_MUL;
            end
        end else begin
            case (state)
                ST_MUL, ST_DIV: begin
                    if (cnt == CNT_LAST) begin
                        result    <= fix_res;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        acc <= (state == ST_MUL) ? mul_next : {div_rem_next, div_quo_next};
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv.sv
// Bench for exec_muldiv: expected results queued at issue, compared on output handshake.
module tb_exec_muldiv;
    import exec_muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      funct3 = 3'd0;
    logic [31:0]     opr1 = '0;
    logic [31:0]     opr2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     result;
    logic            busy;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    exec_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .opr1      (opr1),
        .opr2      (opr2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        up  = {32'b0, a} * {32'b0, b};
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !flush) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL result_unexpected: got %h, required no output", result);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (result !== mon_exp)
                        $display("FAIL result: got %h, required %h", result, mon_exp);
                    else
                        n_pass++;
                end
            end
        end
    endtask

    task automatic wait_valid(input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                n_total++;
                if ({in_ready, busy} !== 2'b01)
                    $display("FAIL %s_stall: got in_ready/busy %b, required 01", name, {in_ready, busy});
                else
                    n_pass++;
            end
        end
        n_total++;
        if (lat !== exp_lat)
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, exp_lat);
        else
            n_pass++;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL %s_ready: got %b, required 1", name, in_ready);
        else
            n_pass++;
        funct3 = f3; opr1 = a; opr2 = b; in_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3 = 3'($urandom_range(0, 7)); opr1 = $urandom; opr2 = $urandom;
        wait_valid(exp_lat, name);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({out_valid, busy, in_ready, result} !== {1'b0, 1'b0, 1'b1, 32'd0})
            $display("FAIL reset: got valid/busy/ready %b%b%b result %h, required 001 00000000",
                     out_valid, busy, in_ready, result);
        else
            n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        logic [2:0]  f;
        run_op(MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
        run_op(MULH,  MINV,          MINV,          32'h4000_0000, 33, "mulh_min");
        run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; f = 3'(i);
            run_op(f, a, b, model(f, a, b), 33, "mul_rand");
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        logic [2:0]  f;
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_-7/2");
        run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_-7/2");
        run_op(DIVU, 32'd100,       32'd7, 32'd14,        33, "divu_100/7");
        run_op(REMU, 32'd100,       32'd7, 32'd2,         33, "remu_100/7");
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom | 32'h1; f = 3'(4 + i);
            run_op(f, a, b, model(f, a, b),
                   (!f[0] && a == MINV && b == 32'hFFFF_FFFF) ? 0 : 33, "div_rand");
        end
    endtask

    task automatic test_special();
        run_op(DIV,  32'd5, 32'd0,         32'hFFFF_FFFF, 0, "div_by0");
        run_op(REM,  32'd5, 32'd0,         32'd5,         0, "rem_by0");
        run_op(DIVU, 32'd9, 32'd0,         32'hFFFF_FFFF, 0, "divu_by0");
        run_op(DIV,  MINV,  32'hFFFF_FFFF, MINV,          0, "div_ovf");
        run_op(REM,  MINV,  32'hFFFF_FFFF, 32'd0,         0, "rem_ovf");
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b0;
        funct3 = MUL; opr1 = 32'd12345; opr2 = 32'd678; in_valid = 1'b1;
        exp_q.push_back(32'd8369910);
        @(posedge clk); #1;
        funct3 = DIVU; opr1 = 32'd1000; opr2 = 32'd7;
        exp_q.push_back(32'd142);
        wait_valid(33, "hold_first");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd8369910})
                $display("FAIL hold_cycle%0d: got valid/ready %b%b result %h, required 10 %h",
                         i, out_valid, in_ready, result, 32'd8369910);
            else
                n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b10)
            $display("FAIL b2b_accept: got busy/valid %b, required 10", {busy, out_valid});
        else
            n_pass++;
        wait_valid(33, "b2b_second");
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic seen;
        @(posedge clk); #1;
        funct3 = MULHU; opr1 = $urandom; opr2 = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b00)
            $display("FAIL flush_midop: got busy/valid %b, required 00", {busy, out_valid});
        else
            n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        n_total++;
        if (seen !== 1'b0)
            $display("FAIL flush_no_output: got out_valid %b, required 0", seen);
        else
            n_pass++;
        flush = 1'b1; in_valid = 1'b1; funct3 = DIV; opr1 = 32'd5; opr2 = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b00)
            $display("FAIL flush_vs_accept: got busy/valid %b, required 00", {busy, out_valid});
        else
            n_pass++;
        out_ready = 1'b0;
        funct3 = MULHU; opr1 = 32'hFFFF_FFFF; opr2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(33, "flush_done_op");
        n_total++;
        if (result !== 32'hFFFF_FFFE)
            $display("FAIL flush_done_value: got %h, required fffffffe", result);
        else
            n_pass++;
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_total++;
        if ({busy, out_valid} !== 2'b00)
            $display("FAIL flush_in_done: got busy/valid %b, required 00", {busy, out_valid});
        else
            n_pass++;
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        funct3 = DIV; opr1 = 32'd1000; opr2 = 32'hFFFF_FFFD; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_total++;
        if ({busy, result} !== {1'b1, 32'hFFFF_FFFE})
            $display("FAIL pre_reset: got busy %b result %h, required 1 fffffffe", busy, result);
        else
            n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({busy, out_valid, result} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL reset_midop: got busy/valid %b%b result %h, required 00 00000000",
                     busy, out_valid, result);
        else
            n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, busy} !== 2'b10)
            $display("FAIL after_reset: got in_ready/busy %b, required 10", {in_ready, busy});
        else
            n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        n_total++;
        if (exp_q.size() !== 0)
            $display("FAIL pending_results: got %0d left, required 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
